// File: rtl/requant_writeback_pkg.sv
// Shared constants and FSM encoding for the requantize/writeback stage.
package requant_writeback_pkg;

    localparam int BW      = 4;
    localparam int PSUM_BW = 16;
    localparam int COL     = 8;
    localparam int ADDR_W  = 11;
    localparam int SHAMT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/requant_writeback_if.sv
// Input vector stream and xmem write port of the writeback stage.
interface requant_writeback_if
    import requant_writeback_pkg::*;
#(
    parameter int bw      = BW,
    parameter int psum_bw = PSUM_BW,
    parameter int col     = COL,
    parameter int addr_w  = ADDR_W
);
    logic                    in_valid;
    logic                    in_ready;
    logic [psum_bw*col-1:0]  in_data;
    logic                    xmem_gnt;
    logic                    xmem_cen;
    logic                    xmem_wen;
    logic [addr_w-1:0]       xmem_addr;
    logic [bw*col-1:0]       xmem_d;

    // writeback block side
    modport slave (
        input  in_valid, in_data, xmem_gnt,
        output in_ready, xmem_cen, xmem_wen, xmem_addr, xmem_d
    );

    // producer / memory side
    modport master (
        output in_valid, in_data, xmem_gnt,
        input  in_ready, xmem_cen, xmem_wen, xmem_addr, xmem_d
    );
endinterface

// File: rtl/requant_writeback_lane_requant.sv
// One lane: signed psum -> round-half-up shift -> unsigned saturate.
module lane_requant
    import requant_writeback_pkg::*;
#(
    parameter int bw      = BW,
    parameter int psum_bw = PSUM_BW,
    parameter int shamt_w = SHAMT_W
) (
    input  logic [psum_bw-1:0] x,
    input  logic [shamt_w-1:0] shamt,
    output logic [bw-1:0]      y
);
    localparam logic [psum_bw:0] SAT = (psum_bw+1)'((1 << bw) - 1);

    logic [psum_bw:0] rnd;
    logic [psum_bw:0] sum;
    logic [psum_bw:0] r;

    // One extra bit on the sum keeps the rounding add from wrapping at full scale.
    always_comb begin
        rnd = '0;
        if (shamt != '0) begin
            rnd = (psum_bw+1)'(1) << (shamt - shamt_w'(1));
        end
        sum = {1'b0, x} + rnd;
        r   = sum >> shamt;
        if (x[psum_bw-1] || (x == '0)) begin
            y = '0;
        end else if (r > SAT) begin
            y = '1;
        end else begin
            y = r[bw-1:0];
        end
    end
endmodule

// File: rtl/requant_writeback.sv
// Requantizes corelet output vectors and writes them to xmem sequentially.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   S_IDLE | waiting for start; params latched when start arrives
//   S_RUN  | accepting vectors and writing them while xmem is granted
//   S_FIN  | one-cycle done pulse, then back to idle
module requant_writeback
    import requant_writeback_pkg::*;
#(
    parameter int bw      = BW,
    parameter int psum_bw = PSUM_BW,
    parameter int col     = COL,
    parameter int addr_w  = ADDR_W,
    parameter int shamt_w = SHAMT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_w-1:0]  base_addr,
    input  logic [addr_w-1:0]  num_vec,
    input  logic [shamt_w-1:0] shamt,
    output logic               busy,
    output logic               done,
    requant_writeback_if.slave bus
);
    state_t              state;
    state_t              state_nxt;
    logic [addr_w-1:0]   base_q;
    logic [addr_w-1:0]   num_q;
    logic [shamt_w-1:0]  shamt_q;
    logic [addr_w-1:0]   acc_cnt;
    logic [addr_w-1:0]   wr_cnt;
    logic                q_valid;
    logic [bw*col-1:0]   q_data;
    logic [bw*col-1:0]   quant;
    logic                wr_fire;
    logic                xfer;
    logic                rdy;

    // A slot opens when the register is empty or drains this same cycle.
    assign wr_fire = q_valid && bus.xmem_gnt;
    assign rdy     = (state == S_RUN) && (acc_cnt < num_q) && (!q_valid || wr_fire);
    assign xfer    = bus.in_valid && rdy;

    assign bus.in_ready  = rdy;
    assign bus.xmem_cen  = !wr_fire;
    assign bus.xmem_wen  = !wr_fire;
    assign bus.xmem_addr = base_q + wr_cnt;
    assign bus.xmem_d    = q_data;

    for (genvar i = 0; i < col; i++) begin : g_lane
        lane_requant #(
            .bw      (bw),
            .psum_bw (psum_bw),
            .shamt_w (shamt_w)
        ) u_lane (
            .x     (bus.in_data[psum_bw*i +: psum_bw]),
            .shamt (shamt_q),
            .y     (quant[bw*i +: bw])
        );
    end

    // Job state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus job status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (num_vec == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (wr_fire && ((wr_cnt + addr_w'(1)) == num_q)) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Job parameters, counters and the single-entry output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q  <= '0;
            num_q   <= '0;
            shamt_q <= '0;
            acc_cnt <= '0;
            wr_cnt  <= '0;
            q_valid <= 1'b0;
            q_data  <= '0;
        end else begin
            if ((state == S_IDLE) && start) begin
                base_q  <= base_addr;
                num_q   <= num_vec;
                shamt_q <= shamt;
                acc_cnt <= '0;
                wr_cnt  <= '0;
                q_valid <= 1'b0;
            end
            if (xfer) begin
                acc_cnt <= acc_cnt + addr_w'(1);
                q_valid <= 1'b1;
                q_data  <= quant;
            end else if (wr_fire) begin
                q_valid <= 1'b0;
            end
            if (wr_fire) begin
                wr_cnt <= wr_cnt + addr_w'(1);
            end
        end
    end
endmodule

// File: tb/tb_requant_writeback.sv
// Randomized bench for requant_writeback against a queue-based reference model.
module tb_requant_writeback;
    localparam int BW = 4, PW = 16, COL = 8, AW = 11, SW = 4;
    localparam int DW = BW*COL;
    localparam int IW = PW*COL;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] num_vec = '0;
    logic [SW-1:0] shamt = '0;
    logic          busy;
    logic          done;

    requant_writeback_if #(.bw(BW), .psum_bw(PW), .col(COL), .addr_w(AW)) bus ();

    requant_writeback #(.bw(BW), .psum_bw(PW), .col(COL), .addr_w(AW), .shamt_w(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_vec   (num_vec),
        .shamt     (shamt),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: job phase 0=idle 1=run 2=fin
    int            m_phase = 0;
    int            m_num = 0, m_acc = 0, m_wr = 0, m_sh = 0;
    logic [AW-1:0] m_base = '0;
    logic [DW-1:0] m_q[$];

    logic [IW-1:0] vec_q[$];
    logic [AW-1:0] wr_addr[$];
    logic [DW-1:0] wr_data[$];
    int            wr_cyc[$];
    int            done_cnt = 0;
    int            cyc_g = 0;
    bit            last_xfer = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_g);
        end
    endtask

    function automatic int ref_lane(int x, int sh);
        int r;
        if (x <= 0) return 0;
        r = (sh == 0) ? x : (x + (1 << (sh - 1))) >> sh;
        return (r > (1 << BW) - 1) ? (1 << BW) - 1 : r;
    endfunction

    function automatic logic [DW-1:0] ref_pack(logic [IW-1:0] d, int sh);
        logic [DW-1:0] p;
        logic [PW-1:0] lane;
        p = '0;
        for (int i = 0; i < COL; i++) begin
            lane = d[PW*i +: PW];
            p[BW*i +: BW] = BW'(ref_lane(int'($signed(lane)), sh));
        end
        return p;
    endfunction

    function automatic logic [IW-1:0] mk_vec(int l0, int l1, int l2, int l3, int l4, int l5, int l6, int l7);
        logic [IW-1:0] v;
        v = {PW'(l7), PW'(l6), PW'(l5), PW'(l4), PW'(l3), PW'(l2), PW'(l1), PW'(l0)};
        return v;
    endfunction

    function automatic logic [IW-1:0] rand_vec();
        logic [IW-1:0] v;
        for (int i = 0; i < COL; i++) begin
            case ($urandom_range(0, 2))
                0:       v[PW*i +: PW] = PW'($urandom);
                1:       v[PW*i +: PW] = PW'($urandom_range(0, 300));
                default: v[PW*i +: PW] = PW'(-$signed($urandom_range(0, 50)));
            endcase
        end
        return v;
    endfunction

    // One clock: drive at negedge, check settled outputs, then advance the model at posedge.
    task automatic step(input bit v, input logic [IW-1:0] data, input bit g, input bit st, input bit rst);
        bit exp_wr, exp_rdy;
        exp_wr  = 1'b0;
        exp_rdy = 1'b0;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_data  = data;
        bus.xmem_gnt = g;
        start        = st;
        reset        = rst;
        #1;
        if (!rst) begin
            exp_wr  = g && (m_q.size() > 0);
            exp_rdy = (m_phase == 1) && (m_acc < m_num) && ((m_q.size() == 0) || g);
            check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            check("xmem_cen", 32'(bus.xmem_cen), 32'(!exp_wr));
            check("xmem_wen", 32'(bus.xmem_wen), 32'(!exp_wr));
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("done", 32'(done), 32'(m_phase == 2));
            if (m_q.size() > 0) begin
                check("xmem_addr", 32'(bus.xmem_addr), 32'(AW'(m_base + AW'(m_wr))));
                check("xmem_d", 32'(bus.xmem_d), 32'(m_q[0]));
            end
            if (!bus.xmem_cen) begin
                wr_addr.push_back(bus.xmem_addr);
                wr_data.push_back(bus.xmem_d);
                wr_cyc.push_back(cyc_g);
            end
            if (done) done_cnt++;
        end
        last_xfer = v && exp_rdy;
        @(posedge clk);
        cyc_g++;
        if (rst) begin
            m_phase = 0;
            m_q.delete();
            m_acc = 0;
            m_wr  = 0;
        end else begin
            case (m_phase)
                0: if (st) begin
                    m_base = base_addr;
                    m_num  = int'(num_vec);
                    m_sh   = int'(shamt);
                    m_acc  = 0;
                    m_wr   = 0;
                    m_q.delete();
                    m_phase = (num_vec == '0) ? 2 : 1;
                end
                1: begin
                    if (exp_wr) begin
                        void'(m_q.pop_front());
                        m_wr++;
                    end
                    if (last_xfer) begin
                        m_q.push_back(ref_pack(data, m_sh));
                        m_acc++;
                    end
                    if (m_wr == m_num) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    // Runs one job from vec_q. stall_at/restart_at/reset_at_wr < 0 disables that event.
    task automatic run_job(input int b, input int n, input int sh, input bit rand_io,
                           input int stall_at, input int restart_at, input int reset_at_wr);
        int cyc;
        bit g, v, st;
        logic [IW-1:0] d;
        base_addr = AW'(b);
        num_vec   = AW'(n);
        shamt     = SW'(sh);
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cnt = 0;
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        cyc = 0;
        while (m_phase != 0 && cyc < 400) begin
            if (reset_at_wr >= 0 && m_wr == reset_at_wr) begin
                step(1'b0, '0, 1'b0, 1'b0, 1'b1);
                return;
            end
            g = rand_io ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 4) g = 1'b0;
            v = (vec_q.size() > 0) && (rand_io ? ($urandom_range(0, 3) != 0) : 1'b1);
            d = (vec_q.size() > 0) ? vec_q[0] : '0;
            st = (cyc == restart_at);
            if (st) begin
                base_addr = AW'(b) ^ AW'('h5A);
                num_vec   = AW'(n + 3);
                shamt     = SW'(sh) ^ SW'(1);
            end
            step(v, d, g, st, 1'b0);
            if (last_xfer) void'(vec_q.pop_front());
            base_addr = AW'(b);
            num_vec   = AW'(n);
            shamt     = SW'(sh);
            cyc++;
        end
        check("job_timeout", 32'(m_phase), 32'(0));
        check("write_count", 32'(wr_addr.size()), 32'(n));
        check("done_pulses", 32'(done_cnt), 32'(1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.xmem_gnt = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // basic job: lanes {4,5,6,60} -> {1,1,2,15}
        vec_q.delete();
        repeat (3) vec_q.push_back(mk_vec(4, 5, 6, 60, 4, 5, 6, 60));
        run_job(16, 3, 2, 1'b0, -1, -1, -1);
        if (wr_addr.size() == 3) begin
            check("basic_addr0", 32'(wr_addr[0]), 32'h010);
            check("basic_addr2", 32'(wr_addr[2]), 32'h012);
            check("basic_data", 32'(wr_data[1]), 32'hF211F211);
            check("basic_back2back", 32'(wr_cyc[2] - wr_cyc[0]), 32'd2);
        end
        idle(2);

        // sign and saturation at shamt=0
        vec_q.delete();
        vec_q.push_back(mk_vec(-3, 0, 15, 16, 32767, -32768, 1, 14));
        run_job(256, 1, 0, 1'b0, -1, -1, -1);
        if (wr_data.size() == 1) check("sat_data", 32'(wr_data[0]), 32'hE10FFF00);

        // widest shift
        vec_q.delete();
        vec_q.push_back(mk_vec(16384, 16384, 16384, 16384, 32767, 1, -1, 8000));
        run_job(300, 1, 15, 1'b0, -1, -1, -1);
        if (wr_data.size() == 1) check("shamt15_data", 32'(wr_data[0]), 32'h00011111);

        // backpressure: four grant-less cycles mid-job
        vec_q.delete();
        repeat (6) vec_q.push_back(rand_vec());
        run_job(64, 6, 3, 1'b0, 3, -1, -1);

        // address wrap
        vec_q.delete();
        repeat (2) vec_q.push_back(rand_vec());
        run_job(2047, 2, 1, 1'b0, -1, -1, -1);
        if (wr_addr.size() == 2) begin
            check("wrap_addr0", 32'(wr_addr[0]), 32'd2047);
            check("wrap_addr1", 32'(wr_addr[1]), 32'd0);
        end

        // empty job
        vec_q.delete();
        run_job(5, 0, 2, 1'b0, -1, -1, -1);

        // start during RUN is ignored
        vec_q.delete();
        repeat (5) vec_q.push_back(rand_vec());
        run_job(500, 5, 4, 1'b1, -1, 2, -1);

        // reset after the first of four writes
        vec_q.delete();
        repeat (4) vec_q.push_back(rand_vec());
        run_job(700, 4, 2, 1'b0, -1, -1, 1);
        idle(6);
        check("reset_writes", 32'(wr_addr.size()), 32'd1);
        check("reset_no_done", 32'(done_cnt), 32'd0);
        vec_q.delete();
        repeat (4) vec_q.push_back(rand_vec());
        run_job(900, 4, 5, 1'b1, -1, -1, -1);
        if (wr_addr.size() == 4) check("post_reset_addr", 32'(wr_addr[3]), 32'd903);

        // random jobs
        for (int j = 0; j < 10; j++) begin
            int n;
            n = $urandom_range(1, 20);
            vec_q.delete();
            repeat (n) vec_q.push_back(rand_vec());
            run_job($urandom_range(0, 2047), n, $urandom_range(0, 15), 1'b1,
                    ($urandom_range(0, 1) != 0) ? $urandom_range(0, 10) : -1, -1, -1);
            idle($urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
